// File: rtl/fault_response_checker.sv
// Response checker for fault-injection passes: records a golden trace, then compares later passes against it
// and emits one result record per fault ID. Optional MISR signature when FRC_MISR_EN is defined.
module fault_response_checker #(
    parameter int DATA_W = 28,
    parameter int STEPS  = 256,
    parameter int FID_W  = 16,
    localparam int SW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pass_start,
    input  logic [FID_W-1:0]  pass_fid,
    input  logic              golden_pass,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FID_W-1:0]  res_fid,
    output logic              res_golden,
    output logic              res_detected,
    output logic [SW-1:0]     res_first_step,
    output logic [SW:0]       res_mismatch_cnt,
    output logic [31:0]       res_signature,
    output logic              err_protocol
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic              golden_ok_q, golden_ok_d;
    logic [FID_W-1:0]  fid_q, fid_d;
    logic              golden_q, golden_d;
    logic [SW:0]       cnt_q, cnt_d;
    logic [SW-1:0]     first_q, first_d;
    logic              err_q, err_d;
    logic              cmp_vld_q;
    logic [SW-1:0]     cmp_step_q;
    logic [DATA_W-1:0] smp_q, gold_q;
    logic [DATA_W-1:0] mem [STEPS];

    logic start_ok, last, take, take_cmp, mis;

    assign start_ok = (state_q == S_IDLE) && pass_start && (golden_pass || golden_ok_q);
    assign last     = (step_q == SW'(STEPS - 1));
    assign take     = smp_valid && ((state_q == S_CAPTURE) || (state_q == S_COMPARE));
    assign take_cmp = smp_valid && (state_q == S_COMPARE);
    // Compare happens one cycle after the read, against the sample registered alongside it.
    assign mis      = cmp_vld_q && (gold_q != smp_q);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        golden_ok_d = golden_ok_q;
        fid_d       = fid_q;
        golden_d    = golden_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        err_d       = (pass_start && (state_q != S_IDLE))
                    || (pass_start && (state_q == S_IDLE) && !golden_pass && !golden_ok_q)
                    || (smp_valid && !take);
        if (mis) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) first_d = cmp_step_q;
        end
        case (state_q)
            S_IDLE: if (start_ok) begin
                state_d  = golden_pass ? S_CAPTURE : S_COMPARE;
                step_d   = '0;
                fid_d    = pass_fid;
                golden_d = golden_pass;
                cnt_d    = '0;
                first_d  = '0;
                if (golden_pass) golden_ok_d = 1'b0;
            end
            S_CAPTURE: if (smp_valid) begin
                step_d = step_q + 1'b1;
                if (last) begin
                    golden_ok_d = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_COMPARE: if (smp_valid) begin
                step_d = step_q + 1'b1;
                if (last) state_d = S_DRAIN;
            end
            S_DRAIN:  state_d = S_REPORT;
            S_REPORT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            golden_ok_q <= 1'b0;
            fid_q       <= '0;
            golden_q    <= 1'b0;
            cnt_q       <= '0;
            first_q     <= '0;
            err_q       <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_step_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            golden_ok_q <= golden_ok_d;
            fid_q       <= fid_d;
            golden_q    <= golden_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            err_q       <= err_d;
            cmp_vld_q   <= take_cmp;
            if (take_cmp) cmp_step_q <= step_q;
        end
    end

    // Single-port golden store: write while capturing, synchronous read while comparing.
    always_ff @(posedge clk) begin
        if (take && (state_q == S_CAPTURE)) mem[step_q] <= smp_data;
        if (take_cmp) begin
            gold_q <= mem[step_q];
            smp_q  <= smp_data;
        end
    end

`ifdef FRC_MISR_EN
    localparam logic [31:0] POLY = 32'h04C11DB7;
    logic [31:0] sig_q;
    always_ff @(posedge clk) begin
        if (!rst_n)        sig_q <= '0;
        else if (start_ok) sig_q <= '1;
        else if (take)     sig_q <= {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ 32'(smp_data);
    end
    assign res_signature = sig_q;
`else
    assign res_signature = '0;
`endif

    assign busy             = (state_q != S_IDLE);
    assign res_valid        = (state_q == S_REPORT);
    assign res_fid          = fid_q;
    assign res_golden       = golden_q;
    assign res_detected     = (cnt_q != '0);
    assign res_first_step   = first_q;
    assign res_mismatch_cnt = cnt_q;
    assign err_protocol     = err_q;
endmodule

// File: tb/tb_fault_response_checker.sv
// Scoreboard bench: stimulus pushes expected records computed from a trace-level model; a monitor pops on handshake.
module tb_fault_response_checker;
    localparam int DATA_W = 28;
    localparam int STEPS  = 256;
    localparam int FID_W  = 16;

    typedef struct {
        logic [FID_W-1:0] fid;
        logic             golden;
        logic             detected;
        logic [7:0]       first;
        logic [8:0]       cnt;
        logic [31:0]      sig;
    } rec_t;

    logic clk = 0, rst_n = 0;
    logic pass_start = 0, golden_pass = 0, smp_valid = 0, res_ready = 1;
    logic [FID_W-1:0] pass_fid = '0;
    logic [DATA_W-1:0] smp_data = '0;
    logic busy, res_valid, res_golden, res_detected, err_protocol;
    logic [FID_W-1:0] res_fid;
    logic [7:0] res_first_step;
    logic [8:0] res_mismatch_cnt;
    logic [31:0] res_signature;

    int vectors = 0, miscompares = 0;
    rec_t exp_q[$];
    logic [DATA_W-1:0] stim [STEPS];
    logic [DATA_W-1:0] gold_ref [STEPS];
    bit gold_valid_ref = 0;

    fault_response_checker #(.DATA_W(DATA_W), .STEPS(STEPS), .FID_W(FID_W)) dut (
        .clk(clk), .rst_n(rst_n), .pass_start(pass_start), .pass_fid(pass_fid),
        .golden_pass(golden_pass), .smp_valid(smp_valid), .smp_data(smp_data),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_fid(res_fid),
        .res_golden(res_golden), .res_detected(res_detected), .res_first_step(res_first_step),
        .res_mismatch_cnt(res_mismatch_cnt), .res_signature(res_signature),
        .err_protocol(err_protocol));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [DATA_W-1:0] d);
        logic [31:0] m;
        m = s << 1;
        if (s[31]) m = m ^ 32'h04C11DB7;
        return m ^ {{(32-DATA_W){1'b0}}, d};
    endfunction

    task automatic chk_rec(input string tag, input rec_t e);
        chk({tag, "_fid"}, 64'(res_fid), 64'(e.fid));
        chk({tag, "_golden"}, 64'(res_golden), 64'(e.golden));
        chk({tag, "_detected"}, 64'(res_detected), 64'(e.detected));
        chk({tag, "_first"}, 64'(res_first_step), 64'(e.first));
        chk({tag, "_cnt"}, 64'(res_mismatch_cnt), 64'(e.cnt));
        chk({tag, "_sig"}, 64'(res_signature), 64'(e.sig));
    endtask

    // Monitor: every accepted record must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_record", 64'(res_valid), 64'd0);
            else chk_rec("rec", exp_q.pop_front());
        end
    end

    // Runs one pass over stim[]; inj/rst_at are step indices (-1 = none), hold = cycles of res_ready low.
    task automatic run_pass(input logic [FID_W-1:0] fid, input bit gp, input bit gaps,
                            input int inj, input int hold, input int rst_at);
        rec_t e;
        int cnt = 0, first = -1;
        logic [31:0] sig = '1;
        for (int i = 0; i < STEPS; i++) begin
            sig = misr(sig, stim[i]);
            if (!gp && stim[i] != gold_ref[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        e.fid = fid; e.golden = gp; e.detected = (cnt != 0);
        e.first = (first < 0) ? 8'd0 : 8'(first); e.cnt = 9'(cnt);
`ifdef FRC_MISR_EN
        e.sig = sig;
`else
        e.sig = 32'd0;
`endif
        exp_q.push_back(e);
        res_ready = (hold == 0);
        pass_start = 1; pass_fid = fid; golden_pass = gp;
        tick();
        pass_start = 0;
        chk("busy_rise", 64'(busy), 64'd1);
        for (int i = 0; i < STEPS; i++) begin
            if (i == rst_at) begin
                smp_valid = 0; rst_n = 0;
                tick();
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_res_valid", 64'(res_valid), 64'd0);
                chk("rst_outputs", 64'({res_fid, res_detected, res_mismatch_cnt, res_first_step, err_protocol}), 64'd0);
                rst_n = 1;
                void'(exp_q.pop_back());
                gold_valid_ref = 0;
                res_ready = 1;
                tick();
                return;
            end
            smp_valid = 1; smp_data = stim[i];
            if (i == inj) begin
                pass_start = 1; pass_fid = 16'h1234; golden_pass = 1;
            end
            tick();
            pass_start = 0;
            if (i == inj) chk("err_start_busy", 64'(err_protocol), 64'd1);
            if (gaps && i != STEPS - 1 && $urandom_range(3) == 0) begin
                smp_valid = 0;
                tick();
            end
        end
        smp_valid = 0;
        if (!gp) begin
            chk("drain_latency", 64'(res_valid), 64'd0);
            tick();
        end
        chk("report_latency", 64'(res_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk_rec("hold", e);
            tick();
        end
        res_ready = 1;
        tick();
        chk("busy_drop", 64'(busy), 64'd0);
        if (gp) begin
            for (int i = 0; i < STEPS; i++) gold_ref[i] = stim[i];
            gold_valid_ref = 1;
        end
    endtask

    task automatic expect_err_idle(input string nm, input bit ps, input bit sv);
        pass_start = ps; golden_pass = 0; pass_fid = 16'h00AA; smp_valid = sv;
        tick();
        pass_start = 0; smp_valid = 0;
        chk({nm, "_err"}, 64'(err_protocol), 64'd1);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        tick();
        chk({nm, "_err_clear"}, 64'(err_protocol), 64'd0);
    endtask

    task automatic mk_mut(input int rate);
        for (int i = 0; i < STEPS; i++)
            stim[i] = gold_ref[i] ^ (($urandom_range(rate - 1) == 0) ? DATA_W'($urandom_range(1, 32'h0FFFFFFF)) : '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(res_valid), 64'd0);
        chk("reset_outputs", 64'({res_fid, res_golden, res_detected, res_first_step, res_mismatch_cnt, res_signature, err_protocol}), 64'd0);
        rst_n = 1;
        tick();

        expect_err_idle("cmp_no_golden", 1, 0);
        expect_err_idle("smp_in_idle", 0, 1);

        for (int i = 0; i < STEPS; i++) stim[i] = DATA_W'(i);
        run_pass(16'hFFFF, 1, 0, -1, 0, -1);
        run_pass(16'h0005, 0, 1, -1, 0, -1);
        stim[10] = stim[10] ^ 1; stim[200] = stim[200] ^ 1;
        run_pass(16'h0007, 0, 0, -1, 0, -1);

        mk_mut(16);
        run_pass(16'h0009, 0, 1, 50, 5, -1);
        mk_mut(64);
        stim[0] = gold_ref[0] ^ 28'h8000001; stim[STEPS-1] = gold_ref[STEPS-1] ^ 28'h1;
        run_pass(16'h000B, 0, 0, -1, 0, -1);
        for (int i = 0; i < STEPS; i++) stim[i] = ~gold_ref[i];
        run_pass(16'h000C, 0, 0, -1, 2, -1);

        for (int i = 0; i < STEPS; i++) stim[i] = DATA_W'($urandom);
        run_pass(16'h0100, 1, 1, -1, 0, -1);
        mk_mut(1000000);
        run_pass(16'h0101, 0, 0, -1, 0, -1);
        for (int k = 0; k < 3; k++) begin
            mk_mut(1 << $urandom_range(1, 6));
            run_pass(16'(16'h0200 + k), 0, 1, -1, $urandom_range(3), -1);
        end

        mk_mut(32);
        run_pass(16'h0300, 0, 0, -1, 0, 100);
        expect_err_idle("cmp_after_reset", 1, 0);

        for (int i = 0; i < STEPS; i++) stim[i] = '0;
        run_pass(16'h0400, 1, 0, -1, 0, -1);
        run_pass(16'h0401, 0, 0, -1, 0, -1);
        run_pass(16'h0402, 0, 0, -1, 0, -1);

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
